// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared types and size defaults for the SPI/host RAM arbiter
package spi_ram_pkg;
  localparam int MEM_DEPTH_DEF = 256;
  localparam int ADDR_SIZE_DEF = 8;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;
  typedef enum logic [1:0] {S_IDLE, S_PEND_WR, S_PEND_RD} spi_st_e;
  typedef enum logic {OWN_SPI, OWN_HOST} owner_e;
endpackage

// File: rtl/spi_ram_arbiter_rr.sv
// rr_arb2: two-way round-robin arbiter, SPI vs host, with registered last-grant pointer
module rr_arb2
  import spi_ram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic spi_req_i,
  input  logic host_req_i,
  output logic spi_gnt_o,
  output logic host_gnt_o
);
  owner_e last_q, last_d;
  // on a tie the requester not granted last time wins; pointer moves only on a grant
  always_comb begin
    spi_gnt_o = spi_req_i && (!host_req_i || last_q == OWN_HOST);
    host_gnt_o = host_req_i && !spi_gnt_o;
    last_d = spi_gnt_o ? OWN_SPI : host_gnt_o ? OWN_HOST : last_q;
  end
  // pointer starts at HOST so SPI takes the first contest
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= OWN_HOST;
    else last_q <= last_d;
endmodule

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: decodes SPI command words and shares one RAM port with a host port
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W+1:0]    rx_data,
  input  logic                 rx_valid,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [DATA_W-1:0]    host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [DATA_W-1:0]    host_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata,
  output logic                 spi_ovf
);
  cmd_e cmd;
  logic [DATA_W-1:0] payload;
  spi_st_e st_q, st_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q, op_addr_q;
  logic [DATA_W-1:0] op_data_q, tx_data_q, host_rdata_q;
  logic tx_valid_q, host_rvalid_q, ovf_q, rd_v_q, rd_oor_q;
  owner_e rd_own_q;
  logic spi_gnt, data_cmd, accept, in_range, rd_issue;
  assign cmd = cmd_e'(rx_data[DATA_W+1:DATA_W]);
  assign payload = rx_data[DATA_W-1:0];
  assign data_cmd = rx_valid && (cmd == CMD_WR_DATA || cmd == CMD_RD_DATA);
  assign accept = data_cmd && (st_q == S_IDLE || spi_gnt);
  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .spi_req_i (st_q != S_IDLE),
    .host_req_i(host_req),
    .spi_gnt_o (spi_gnt),
    .host_gnt_o(host_gnt)
  );
  // SPI state register
  always_ff @(posedge clk or posedge rst)
    if (rst) st_q <= S_IDLE;
    else st_q <= st_d;
  // a data command accepted in the same cycle the pending op issues re-arms the pend
  always_comb
    st_d = accept ? (cmd == CMD_WR_DATA ? S_PEND_WR : S_PEND_RD) : spi_gnt ? S_IDLE : st_q;
  // RAM port driven by the winner; out-of-range ops are granted but never reach the RAM
  always_comb begin
    ram_we = spi_gnt ? st_q == S_PEND_WR : host_gnt && host_we;
    ram_addr = spi_gnt ? op_addr_q : host_gnt ? host_addr : '0;
    ram_wdata = spi_gnt ? op_data_q : host_gnt ? host_wdata : '0;
    in_range = 32'(ram_addr) < MEM_DEPTH;
    ram_en = (spi_gnt || host_gnt) && in_range;
    rd_issue = (spi_gnt || host_gnt) && !ram_we;
  end
  // address registers, pending-op latch, overflow flag and one-stage read-return pipe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      op_addr_q <= '0;
      op_data_q <= '0;
      ovf_q <= 1'b0;
      rd_v_q <= 1'b0;
      rd_own_q <= OWN_SPI;
      rd_oor_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      if (rx_valid && cmd == CMD_WR_ADDR) wr_addr_q <= ADDR_SIZE'(payload);
      if (rx_valid && cmd == CMD_RD_ADDR) rd_addr_q <= ADDR_SIZE'(payload);
      if (accept) begin
        op_addr_q <= cmd == CMD_WR_DATA ? wr_addr_q : rd_addr_q;
        op_data_q <= payload;
      end
      if (data_cmd && !accept) ovf_q <= 1'b1;
      rd_v_q <= rd_issue;
      rd_own_q <= spi_gnt ? OWN_SPI : OWN_HOST;
      rd_oor_q <= !in_range;
      tx_valid_q <= rd_v_q && rd_own_q == OWN_SPI;
      host_rvalid_q <= rd_v_q && rd_own_q == OWN_HOST;
      if (rd_v_q && rd_own_q == OWN_SPI) tx_data_q <= rd_oor_q ? '0 : ram_rdata;
      if (rd_v_q && rd_own_q == OWN_HOST) host_rdata_q <= rd_oor_q ? '0 : ram_rdata;
    end
  assign tx_valid = tx_valid_q;
  assign tx_data = tx_data_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata = host_rdata_q;
  assign spi_ovf = ovf_q;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: directed plus random stimulus against a transaction-level reference model
module tb_spi_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic tx_valid;
  logic host_req = 1'b0, host_we = 1'b0;
  logic [7:0] host_addr = '0, host_wdata = '0;
  logic host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata = '0;
  logic spi_ovf;

  spi_ram_arbiter dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .spi_ovf(spi_ovf)
  );

  always #5 clk = ~clk;

  // environment RAM: synchronous, read data appears the cycle after the access
  logic [7:0] ram [256];
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else ram_rdata <= ram[ram_addr];
    end

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: ideal memory, address registers, pending SPI op, last winner, in-flight read
  logic [7:0] mm [256];
  logic [7:0] m_wr, m_rd, m_paddr, m_pdata, fl_data;
  int m_pend, m_last, fl_own;
  bit m_ovf, fl_v, e_txv, e_hv;
  logic [7:0] e_txd, e_hd;
  bit nh_req, nh_we, host_hold, rand_host;
  logic [7:0] nh_addr, nh_wd;

  task automatic step(input bit r, input bit v, input logic [9:0] d);
    int win;
    bit xen, xwe;
    logic [7:0] xa, xd, pl;
    logic [1:0] c;
    @(negedge clk);
    if (r) nh_req = 0;
    else if (rand_host && !nh_req && $urandom_range(3) == 0) begin
      nh_req = 1;
      nh_we = 1'($urandom_range(1));
      nh_addr = 8'($urandom_range(63));
      nh_wd = 8'($urandom);
    end
    rst = r;
    rx_valid = v;
    rx_data = d;
    host_req = nh_req;
    host_we = nh_we;
    host_addr = nh_addr;
    host_wdata = nh_wd;
    #1;
    if (r) begin
      m_wr = 0; m_rd = 0; m_pend = 0; m_last = 1; m_ovf = 0;
      fl_v = 0; e_txv = 0; e_hv = 0; e_txd = 0; e_hd = 0;
    end
    win = -1;
    if (m_pend != 0 && host_req) win = (m_last == 1) ? 0 : 1;
    else if (m_pend != 0) win = 0;
    else if (host_req) win = 1;
    xen = win >= 0;
    xwe = (win == 0) ? (m_pend == 1) : (win == 1) ? host_we : 1'b0;
    xa = (win == 0) ? m_paddr : (win == 1) ? host_addr : 8'h00;
    xd = (win == 0) ? m_pdata : host_wdata;
    chk("ram_en", 32'(ram_en), 32'(xen));
    chk("ram_we", 32'(ram_we), 32'(xwe));
    if (xen) chk("ram_addr", 32'(ram_addr), 32'(xa));
    if (xen && xwe) chk("ram_wdata", 32'(ram_wdata), 32'(xd));
    chk("host_gnt", 32'(host_gnt), 32'(win == 1));
    chk("tx_valid", 32'(tx_valid), 32'(e_txv));
    chk("tx_data", 32'(tx_data), 32'(e_txd));
    chk("host_rvalid", 32'(host_rvalid), 32'(e_hv));
    chk("host_rdata", 32'(host_rdata), 32'(e_hd));
    chk("spi_ovf", 32'(spi_ovf), 32'(m_ovf));
    if (!r) begin
      e_txv = fl_v && fl_own == 0;
      e_hv = fl_v && fl_own == 1;
      if (e_txv) e_txd = fl_data;
      if (e_hv) e_hd = fl_data;
      fl_v = xen && !xwe;
      fl_own = win;
      fl_data = mm[xa];
      if (xen && xwe) mm[xa] = xd;
      if (xen) m_last = win;
      if (win == 1 && !host_hold) nh_req = 0;
      if (win == 0) m_pend = 0;
      c = d[9:8];
      pl = d[7:0];
      if (v) begin
        if (c == 2'b00) m_wr = pl;
        else if (c == 2'b10) m_rd = pl;
        else if (m_pend == 0) begin
          m_pend = (c == 2'b01) ? 1 : 2;
          m_paddr = (c == 2'b01) ? m_wr : m_rd;
          m_pdata = pl;
        end else m_ovf = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 10'h000);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      mm[i] = 8'h00;
    end
    nh_req = 0; nh_we = 0; nh_addr = 0; nh_wd = 0; host_hold = 0; rand_host = 0;
    step(1, 0, 10'h000);
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_ovf", 32'(spi_ovf), 32'd0);
    idle(1);
    // SPI write then read back of 0xA5
    step(0, 1, 10'h0A5); step(0, 1, 10'h13C); step(0, 1, 10'h2A5); step(0, 1, 10'h300);
    idle(3);
    chk("tp1_txv", 32'(tx_valid), 32'd1);
    chk("tp1_txd", 32'(tx_data), 32'h3C);
    chk("tp1_mem", 32'(ram[8'hA5]), 32'h3C);
    // contention right after reset: SPI first, host next cycle
    step(1, 0, 10'h000);
    step(0, 1, 10'h177);
    nh_req = 1; nh_we = 0; nh_addr = 8'h10;
    step(0, 0, 10'h000);
    chk("tp2_spi_first", 32'(ram_we), 32'd1);
    chk("tp2_hgnt0", 32'(host_gnt), 32'd0);
    step(0, 0, 10'h000);
    chk("tp2_hgnt1", 32'(host_gnt), 32'd1);
    idle(3);
    // overflow with host held writing
    nh_req = 1; nh_we = 1; nh_addr = 8'h50; nh_wd = 8'h99; host_hold = 1;
    step(0, 1, 10'h101); step(0, 1, 10'h102); step(0, 1, 10'h103);
    host_hold = 0;
    idle(1);
    chk("tp3_ovf", 32'(spi_ovf), 32'd1);
    idle(10);
    chk("tp3_ovf_sticky", 32'(spi_ovf), 32'd1);
    // back-to-back host then SPI reads
    ram[8'h20] = 8'h11; mm[8'h20] = 8'h11;
    ram[8'h21] = 8'h22; mm[8'h21] = 8'h22;
    step(0, 1, 10'h221);
    nh_req = 1; nh_we = 0; nh_addr = 8'h20;
    step(0, 1, 10'h300);
    idle(2);
    chk("tp4_hv", 32'(host_rvalid), 32'd1);
    chk("tp4_hd", 32'(host_rdata), 32'h11);
    chk("tp4_txv0", 32'(tx_valid), 32'd0);
    idle(1);
    chk("tp4_txv", 32'(tx_valid), 32'd1);
    chk("tp4_txd", 32'(tx_data), 32'h22);
    chk("tp4_hv0", 32'(host_rvalid), 32'd0);
    // reset the cycle after an SPI read issues
    idle(2);
    step(0, 1, 10'h300);
    idle(1);
    step(1, 0, 10'h000);
    idle(3);
    chk("tp5_txv", 32'(tx_valid), 32'd0);
    chk("tp5_ovf", 32'(spi_ovf), 32'd0);
    step(0, 1, 10'h1AA);
    nh_req = 1; nh_we = 1; nh_addr = 8'h30; nh_wd = 8'h44;
    step(0, 0, 10'h000);
    chk("tp5_spi_win", 32'(host_gnt), 32'd0);
    chk("tp5_addr", 32'(ram_addr), 32'h00);
    idle(3);
    // address retention across two writes
    step(0, 1, 10'h040); step(0, 1, 10'h101); step(0, 1, 10'h102);
    idle(2);
    chk("tp6_mem", 32'(ram[8'h40]), 32'h02);
    // random traffic
    rand_host = 1;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(199) == 0, 1'($urandom_range(1)), {2'($urandom), 8'($urandom_range(63))});
    rand_host = 0;
    step(1, 0, 10'h000);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Sits between the SPI slave and the single-port RAM.
- Decodes 10-bit SPI command words, holds RAM write/read addresses, and shares the one RAM port between the SPI command stream and a local host port using a 2-way round-robin arbiter.
- Returns read data to whichever requester issued the read.
- Issues at most one RAM operation per clock.

Parameters:
- MEM_DEPTH, 256, number of RAM words.
- ADDR_SIZE, 8, RAM address width.
- DATA_W, 8, RAM data width; SPI payload width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- rx_data  in  10  SPI command word: [9:8] cmd, [7:0] payload
- rx_valid  in  1  single-cycle strobe; rx_data valid this cycle
- tx_data  out  DATA_W  read data returned to the SPI slave
- tx_valid  out  1  single-cycle strobe; tx_data valid
- host_req  in  1  host request; held with fields stable until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_SIZE  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  combinational; high in the cycle the host op is issued to RAM
- host_rvalid  out  1  single-cycle strobe; host_rdata valid
- host_rdata  out  DATA_W  host read data
- ram_en  out  1  RAM access enable (combinational)
- ram_we  out  1  RAM write enable (combinational)
- ram_addr  out  ADDR_SIZE  RAM address (combinational)
- ram_wdata  out  DATA_W  RAM write data (combinational)
- ram_rdata  in  DATA_W  RAM read data; valid the cycle after a read issue
- spi_ovf  out  1  sticky flag: SPI command dropped; cleared only by rst

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: all registered outputs 0 (tx_valid, tx_data, host_rvalid, host_rdata, spi_ovf).
  - wr_addr and rd_addr = 0; SPI FSM = S_IDLE; rr pointer = HOST, so SPI wins the first contest.
- SPI decode, on rx_valid, by cmd:
  - 00 (WR_ADDR): wr_addr <= payload. No RAM access.
  - 10 (RD_ADDR): rd_addr <= payload. No RAM access.
  - 01 (WR_DATA): FSM S_IDLE -> S_PEND_WR, latching payload.
  - 11 (RD_DATA): FSM S_IDLE -> S_PEND_RD.
- While the FSM is in S_PEND_WR or S_PEND_RD:
  - A further WR_DATA or RD_DATA command is dropped and spi_ovf <= 1.
  - WR_ADDR and RD_ADDR still update their address registers; the pending op keeps its already-latched address.
- The SPI op latches its address at pend time: S_PEND_WR uses wr_addr, S_PEND_RD uses rd_addr.
- Arbitration (rr_arb2), each cycle:
  - Requesters: spi_req = (FSM != S_IDLE); host_req.
  - One requester -> it wins. Both -> the one not granted last wins.
  - The rr pointer updates only when a grant is issued.
- Issue cycle:
  - ram_en = 1; ram_we, ram_addr, ram_wdata taken from the winner.
  - SPI winner: FSM -> S_IDLE at the next edge.
  - Host winner: host_gnt = 1.
  - Idle cycle: ram_en = 0, ram_we = 0, other RAM fields 0.
- Read return:
  - A 1-stage owner pipe records (read issued, owner).
  - One cycle after issue, ram_rdata is registered into tx_data or host_rdata.
  - The matching strobe is high for exactly one cycle.
  - Read latency: issue edge + 2, i.e. strobe is visible 2 cycles after the ram_en cycle.
  - Back-to-back issues are allowed; returns stay in order and never overlap for the same owner.
- Uncontested SPI RD_DATA: rx_valid at cycle N -> issue at N+1 -> tx_valid at N+3.
- Out of range (only if MEM_DEPTH < 2**ADDR_SIZE), address >= MEM_DEPTH:
  - The op is still granted, but ram_en is forced to 0.
  - A read returns 0 with the normal strobe timing.
- Simultaneous events:
  - rx_valid with WR_DATA/RD_DATA in the same cycle an SPI grant clears the pend is accepted (no overflow); the new op pends next cycle.
  - host_req deasserted before grant is a protocol violation; behaviour unspecified.
- Reset mid-operation: pending op and in-flight read are discarded; no strobe follows reset release.

Decomposition:
- Package spi_ram_pkg:
  - cmd_e enum: CMD_WR_ADDR = 2'b00, CMD_WR_DATA = 2'b01, CMD_RD_ADDR = 2'b10, CMD_RD_DATA = 2'b11.
  - spi_st_e enum: S_IDLE, S_PEND_WR, S_PEND_RD.
  - owner_e enum: OWN_SPI, OWN_HOST.
  - Shared MEM_DEPTH and ADDR_SIZE defaults.
- Sub-module rr_arb2: 2-way round-robin arbiter with registered last-grant pointer, clk/rst ports.

Test Plan:
- SPI write/read: rx 0x0_A5 (addr), rx 0x1_3C, rx 0x2_A5, rx 0x3_00 -> RAM write at 0xA5 with 0x3C; tx_valid one cycle with tx_data = 0x3C, 3 cycles after the last rx_valid.
- Contention: SPI WR_DATA pending and host_req read of 0x10 in the same cycle after reset -> SPI issues first; host_gnt next cycle; next tie goes to host.
- Overflow: host_req held continuously writing, with two consecutive WR_DATA commands while the first is still pending (host currently granted) -> second dropped, spi_ovf = 1 and stays 1 until rst.
- Back-to-back reads: host read 0x20 then SPI read 0x21 in consecutive cycles, RAM preloaded 0x11/0x22 -> host_rvalid with 0x11, then tx_valid with 0x22 one cycle later; no cross-delivery.
- Reset mid-read: rst asserted the cycle after an SPI read issue -> tx_valid never asserted; all outputs 0; next SPI command wins arbitration.
- Address retention: WR_ADDR 0x40, WR_DATA 0x01, WR_DATA 0x02 -> both writes go to 0x40; final RAM[0x40] = 0x02.
